// File: rtl/arbitro_mux4_pkg.sv
// rtl/arbitro_mux4_pkg.sv - shared types and constants for the 4-way round-robin selector arbiter
package arbitro_mux4_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } state_e;

  // Turns a requester index into its one-hot grant pattern.
  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/arbitro_mux4_prio_rr4.sv
// rtl/arbitro_mux4_prio_rr4.sv - combinational first-set search starting at a rotating pointer
module prio_rr4
  import arbitro_mux4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Scan from the farthest position back to start so the nearest set bit wins.
  always_comb begin
    logic [SEL_W-1:0] pos;
    found = 1'b0;
    idx   = start;
    pos   = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = start + SEL_W'(k);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux4.sv
// rtl/arbitro_mux4.sv - round-robin arbiter with hold limit driving a 4:1 selector
module arbitro_mux4
  import arbitro_mux4_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valido,
  output logic             troca
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valido_q, valido_d;
  logic             troca_q, troca_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // While granted, sel_q is the current holder; its successor starts the search.
  logic [SEL_W-1:0] next_start;
  logic [N_REQ-1:0] others;
  logic             found_idle, found_busy;
  logic [SEL_W-1:0] idx_idle, idx_busy;

  assign next_start = sel_q + SEL_W'(1);
  assign others     = req & ~onehot4(sel_q);

  prio_rr4 u_prio_idle (
    .req   (req),
    .start (ptr_q),
    .found (found_idle),
    .idx   (idx_idle)
  );

  prio_rr4 u_prio_busy (
    .req   (others),
    .start (next_start),
    .found (found_busy),
    .idx   (idx_busy)
  );

  // Next-state and registered-output decisions for idle and granted phases.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    valido_d = valido_q;
    troca_d  = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      OCIOSO: begin
        if (found_idle) begin
          state_d  = CONCEDIDO;
          gnt_d    = onehot4(idx_idle);
          sel_d    = idx_idle;
          valido_d = 1'b1;
          troca_d  = 1'b1;
          cnt_d    = CNT_ONE;
        end
      end
      CONCEDIDO: begin
        if (!req[sel_q]) begin
          ptr_d = next_start;
          if (found_busy) begin
            gnt_d   = onehot4(idx_busy);
            sel_d   = idx_busy;
            troca_d = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            // sel keeps the last holder so the selector input stays stable.
            state_d  = OCIOSO;
            gnt_d    = '0;
            valido_d = 1'b0;
            cnt_d    = '0;
          end
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LIM) && found_busy) begin
          ptr_d   = next_start;
          gnt_d   = onehot4(idx_busy);
          sel_d   = idx_busy;
          troca_d = 1'b1;
          cnt_d   = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = OCIOSO;
        gnt_d    = '0;
        valido_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCIOSO;
      gnt_q    <= '0;
      sel_q    <= '0;
      valido_q <= 1'b0;
      troca_q  <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      valido_q <= valido_d;
      troca_q  <= troca_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign valido = valido_q;
  assign troca  = troca_q;

endmodule

// File: tb/tb_arbitro_mux4.sv
// tb/tb_arbitro_mux4.sv - scoreboard bench for the round-robin selector arbiter
module tb_arbitro_mux4;

  localparam int MH    = 4;
  localparam int CW    = 4;
  localparam int CSAT  = (1 << CW) - 1;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valido;
    logic       troca;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valido;
  logic       troca;

  exp_t sb[$];
  int   n_cmp;
  int   n_mis;

  // Reference model state
  bit       m_busy;
  int       m_c;
  int       m_ptr;
  int       m_cnt;
  int       m_sel;
  bit       m_troca;

  arbitro_mux4 #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .valido (valido),
    .troca  (troca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_c = 0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_troca = 0;
  endtask

  task automatic model_take(input int i);
    m_busy = 1; m_c = i; m_sel = i; m_cnt = 1; m_troca = 1;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    int nxt;
    m_troca = 0;
    if (!m_busy) begin
      nxt = search(r, m_ptr);
      if (nxt >= 0) model_take(nxt);
    end else begin
      oth = r;
      oth[m_c] = 1'b0;
      nxt = search(oth, (m_c + 1) % 4);
      if (!r[m_c]) begin
        m_ptr = (m_c + 1) % 4;
        if (nxt >= 0) model_take(nxt);
        else begin m_busy = 0; m_cnt = 0; end
      end else if (MH != 0 && m_cnt == MH && nxt >= 0) begin
        m_ptr = (m_c + 1) % 4;
        model_take(nxt);
      end else if (m_cnt < CSAT) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.gnt    = m_busy ? (4'b0001 << m_c) : 4'b0000;
    e.sel    = 2'(m_sel);
    e.valido = m_busy;
    e.troca  = m_troca;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_mis++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (gnt === e.gnt) else begin
        n_mis++;
        $error("FAIL %s gnt: observed %b expected %b", tag, gnt, e.gnt);
      end
      n_cmp++;
      assert (sel === e.sel) else begin
        n_mis++;
        $error("FAIL %s sel: observed %b expected %b", tag, sel, e.sel);
      end
      n_cmp++;
      assert (valido === e.valido) else begin
        n_mis++;
        $error("FAIL %s valido: observed %b expected %b", tag, valido, e.valido);
      end
      n_cmp++;
      assert (troca === e.troca) else begin
        n_mis++;
        $error("FAIL %s troca: observed %b expected %b", tag, troca, e.troca);
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    model_step(r);
    push_expected();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    model_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    push_expected();
    check("reset");
    rst_n = 1'b1;

    // Round robin with everyone requesting: 4 cycles per holder, then wrap.
    for (int i = 0; i < 17; i++) step(4'b1111, "round_robin");

    // Holder 0 drops, 1 takes over, then 1 drops and 3 follows with no gap.
    step(4'b1010, "to_holder1");
    step(4'b1000, "release_handoff");

    // Lone requester holds far past the counter's saturation point.
    for (int i = 0; i < 20; i++) step(4'b0100, "lone_holder");

    // Holder 3 releases to idle, then the pointer has wrapped to 0.
    step(4'b1000, "to_holder3");
    step(4'b0000, "idle_sel_hold");
    step(4'b0000, "idle_stay");
    step(4'b0011, "wrap_grant0");

    // Reset mid-grant between edges must clear outputs without a clock.
    step(4'b0100, "to_holder2");
    step(4'b0100, "holder2_keep");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_expected();
    check("async_reset");
    #1;
    rst_n = 1'b1;
    step(4'b0110, "after_reset");

    // Mixed random traffic against the model.
    for (int i = 0; i < 60; i++) step(4'($urandom_range(0, 15)), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
